sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO with registered read data, fill-level reporting, programmable almost-full/almost-empty thresholds and a synchronous flush. It is the drop-in successor to the team's basic synchronous FIFO for datapath buffering between producer and consumer blocks in the same clock domain. It adds the status needed for flow control ahead of the full/empty limits, plus optional sticky overflow/underflow error reporting.

---
 rtl/sync_fifo_flags_if.sv | 32 +++
 rtl/sync_fifo_flags.sv | 104 ++++++++++
 tb/tb_sync_fifo_flags.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// Bus bundle for sync_fifo_flags: request/data signals from the producer/consumer
// side and status/read data returned by the FIFO.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  cs;
  logic                  wr_ena;
  logic                  rd_ena;
  logic                  flush;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output cs, wr_ena, rd_ena, flush, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  cs, wr_ena, rd_ena, flush, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered read data, level flags and synchronous flush.
// Define SYNC_FIFO_ERR_EN to build sticky overflow/underflow error registers.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_flags_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_THRESH = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_THRESH = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]         wr_ptr_reg;
  logic [CW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         wr_ptr_next;
  logic [CW-1:0]         rd_ptr_next;
  logic [DATA_WIDTH-1:0] data_out_reg;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] count_w;
  logic          full_w;
  logic          empty_w;
  logic          flush_acc;
  logic          wr_acc;
  logic          rd_acc;

  // Status is decoded only from the pointer registers, never from inputs.
  assign wr_idx  = wr_ptr_reg[AW-1:0];
  assign rd_idx  = rd_ptr_reg[AW-1:0];
  assign count_w = wr_ptr_reg - rd_ptr_reg;
  assign full_w  = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign empty_w = (wr_ptr_reg == rd_ptr_reg);

  assign flush_acc = bus.cs & bus.flush;
  assign wr_acc    = bus.cs & bus.wr_ena & ~full_w  & ~bus.flush;
  assign rd_acc    = bus.cs & bus.rd_ena & ~empty_w & ~bus.flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush_acc) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_acc) wr_ptr_next = wr_ptr_reg + CW'(1);
      if (rd_acc) rd_ptr_next = rd_ptr_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      data_out_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (rd_acc) data_out_reg <= mem[rd_idx];
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= bus.data_in;
  end

  assign bus.data_out     = data_out_reg;
  assign bus.count        = count_w;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_w >= AF_THRESH);
  assign bus.almost_empty = (count_w <= AE_THRESH);

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush_acc) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.cs & bus.wr_ena & full_w)  overflow_reg  <= 1'b1;
      if (bus.cs & bus.rd_ena & empty_w) underflow_reg <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags with a queue model of contents and a
// scoreboard of expected read data; checks every output after each cycle.
module tb_sync_fifo_flags;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_LEVEL(DEPTH-2), .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];      // model of FIFO contents
  logic [DW-1:0] exp_q[$];   // scoreboard of expected read data
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf  = 1'b0;
  bit            m_unf  = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    int sz;
    sz = mq.size();
    chk({step, ".data_out"},     bus.data_out, m_dout);
    chk({step, ".count"},        DW'(bus.count), DW'(sz));
    chk({step, ".full"},         DW'(bus.full), DW'(sz == DEPTH));
    chk({step, ".empty"},        DW'(bus.empty), DW'(sz == 0));
    chk({step, ".almost_full"},  DW'(bus.almost_full), DW'(sz >= DEPTH-2));
    chk({step, ".almost_empty"}, DW'(bus.almost_empty), DW'(sz <= 2));
    chk({step, ".overflow"},     DW'(bus.overflow), DW'(m_ovf));
    chk({step, ".underflow"},    DW'(bus.underflow), DW'(m_unf));
    $display("%s: cs=%0b wr=%0b rd=%0b fl=%0b din=%0h -> count=%0d dout=%0h ovf=%0b unf=%0b",
             step, bus.cs, bus.wr_ena, bus.rd_ena, bus.flush, bus.data_in,
             bus.count, bus.data_out, bus.overflow, bus.underflow);
  endtask

  // One clock cycle: drive, update model, clock, then compare everything.
  task automatic cycle(input string step, input logic c, input logic w, input logic r,
                       input logic f, input logic [DW-1:0] d);
    bit mfull, mempty, racc;
    mfull  = (mq.size() == DEPTH);
    mempty = (mq.size() == 0);
    racc   = 1'b0;
    bus.cs = c; bus.wr_ena = w; bus.rd_ena = r; bus.flush = f; bus.data_in = d;
    if (c && f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (c && w && mfull)  m_ovf = ERR;
      if (c && r && mempty) m_unf = ERR;
      if (c && r && !mempty) begin
        exp_q.push_back(mq.pop_front());
        racc = 1'b1;
      end
      if (c && w && !mfull) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    if (racc) m_dout = exp_q.pop_front();
    check_all(step);
  endtask

  initial begin
    bus.cs = 1'b0; bus.wr_ena = 1'b0; bus.rd_ena = 1'b0; bus.flush = 1'b0; bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Fill 1..8, then a rejected 9th write.
    for (int i = 1; i <= DEPTH; i++) cycle($sformatf("fill%0d", i), 1, 1, 0, 0, DW'(i));
    cycle("write_full", 1, 1, 0, 0, 32'h99);

    // Drain 8, then a rejected read.
    for (int i = 1; i <= DEPTH; i++) cycle($sformatf("drain%0d", i), 1, 0, 1, 0, '0);
    cycle("read_empty", 1, 0, 1, 0, '0);

    // Deselected requests are ignored, including flush.
    cycle("cs_low", 0, 1, 1, 1, 32'h55);

    // Count 4, then 10 cycles of simultaneous read/write across wrap.
    for (int i = 0; i < 4; i++) cycle($sformatf("pre%0d", i), 1, 1, 0, 0, 32'h10 + DW'(i));
    for (int i = 0; i < 10; i++) cycle($sformatf("rw%0d", i), 1, 1, 1, 0, 32'h14 + DW'(i));

    // Full with read+write: only the read is taken.
    for (int i = 0; i < 4; i++) cycle($sformatf("top%0d", i), 1, 1, 0, 0, 32'h30 + DW'(i));
    cycle("full_rw", 1, 1, 1, 0, 32'h40);
    for (int i = 0; i < DEPTH-1; i++) cycle($sformatf("empt%0d", i), 1, 0, 1, 0, '0);
    // Empty with read+write: only the write is taken, data_out held.
    cycle("empty_rw", 1, 1, 1, 0, 32'h50);

    // Build count 5 with both error flags raised, then flush with wr/rd.
    cycle("pop1", 1, 0, 1, 0, '0);
    cycle("unf", 1, 0, 1, 0, '0);
    for (int i = 0; i < DEPTH; i++) cycle($sformatf("ld%0d", i), 1, 1, 0, 0, 32'h60 + DW'(i));
    cycle("ovf", 1, 1, 0, 0, 32'h6f);
    for (int i = 0; i < 3; i++) cycle($sformatf("rd5_%0d", i), 1, 0, 1, 0, '0);
    cycle("flush", 1, 1, 1, 1, 32'h77);

    // Asynchronous reset mid-stream at count 3.
    for (int i = 0; i < 3; i++) cycle($sformatf("pre_rst%0d", i), 1, 1, 0, 0, 32'h80 + DW'(i));
    cycle("pre_rst_rd", 1, 1, 1, 0, 32'h83);
    bus.cs = 1'b0; bus.wr_ena = 1'b0; bus.rd_ena = 1'b0; bus.flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    mq.delete(); exp_q.delete();
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    check_all("async_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    cycle("post_wr", 1, 1, 0, 0, 32'hA5A5_0001);
    cycle("post_rd", 1, 0, 1, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
